// File: rtl/flash_access_arb.sv
// Round-robin arbiter granting one channel at a time to the flash
// read/write engines, with a per-operation watchdog.
module flash_access_arb #(
  parameter int                CH_NUM   = 2,
  parameter int                ADDR_SZ  = 16,
  parameter int                TOUT_W   = 20,
  parameter logic [TOUT_W-1:0] TOUT_MAX = 20'hFFFFF
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [CH_NUM-1:0]         i_wr_req,
  input  logic [CH_NUM-1:0]         i_rd_req,
  input  logic [CH_NUM*ADDR_SZ-1:0] i_addr_offset,
  input  logic [CH_NUM*ADDR_SZ-1:0] i_data_len,
  output logic [CH_NUM-1:0]         o_grant,
  output logic [CH_NUM-1:0]         o_done,
  output logic [CH_NUM-1:0]         o_err,
  output logic                      o_busy,
  output logic                      o_wr_irq,
  output logic                      o_rd_irq,
  output logic [ADDR_SZ-1:0]        o_addr_offset,
  output logic [ADDR_SZ-1:0]        o_data_len,
  input  logic                      i_wr_dn,
  input  logic                      i_rd_dn,
  input  logic                      i_scl_w,
  input  logic                      i_scl_r,
  output logic                      o_scl
);

  localparam int CW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WR   = 3'd1;
  localparam logic [2:0] S_RD   = 3'd2;
  localparam logic [2:0] S_FIN  = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  localparam logic [TOUT_W-1:0] T_LAST = TOUT_MAX - 1'b1;

  logic [2:0]          state_q, state_d;
  logic [CW-1:0]       ptr_q, ptr_d;
  logic [CW-1:0]       ch_q, ch_d;
  logic [TOUT_W-1:0]   cnt_q, cnt_d;
  logic [CH_NUM-1:0]   grant_q, grant_d;
  logic [CH_NUM-1:0]   done_q, done_d;
  logic [CH_NUM-1:0]   err_q, err_d;
  logic                busy_q, busy_d;
  logic                wr_irq_q, wr_irq_d;
  logic                rd_irq_q, rd_irq_d;
  logic [ADDR_SZ-1:0]  addr_q, addr_d;
  logic [ADDR_SZ-1:0]  len_q, len_d;

  logic [CH_NUM-1:0]   any_req;
  logic [CH_NUM-1:0]   rot;
  logic                sel_found;
  logic [CW:0]         sel_off;
  logic [CW:0]         sel_sum;
  logic [CW-1:0]       sel_ch;
  logic [CH_NUM-1:0]   sel_oh;
  logic                sel_wr;
  logic [CW-1:0]       ptr_nxt;

  assign o_scl = i_scl_w | i_scl_r;

  // Rotate requests so the search starts at ptr; lowest offset wins.
  always_comb begin
    any_req   = i_wr_req | i_rd_req;
    rot       = CH_NUM'({any_req, any_req} >> ptr_q);
    sel_found = 1'b0;
    sel_off   = '0;
    for (int i = CH_NUM - 1; i >= 0; i--) begin
      if (rot[i]) begin
        sel_found = 1'b1;
        sel_off   = (CW+1)'(i);
      end
    end
    sel_sum = {1'b0, ptr_q} + sel_off;
    if (sel_sum >= (CW+1)'(CH_NUM)) begin
      sel_sum = sel_sum - (CW+1)'(CH_NUM);
    end
    sel_ch  = CW'(sel_sum);
    sel_oh  = CH_NUM'(1) << sel_ch;
    sel_wr  = |(i_wr_req & sel_oh);
    ptr_nxt = (ch_q == CW'(CH_NUM - 1)) ? '0 : ch_q + 1'b1;
  end

  // Next state, watchdog and registered-output values.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ch_d    = ch_q;
    cnt_d   = '0;
    addr_d  = addr_q;
    len_d   = len_q;
    unique case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          ch_d    = sel_ch;
          addr_d  = ADDR_SZ'(i_addr_offset >> (int'(sel_ch) * ADDR_SZ));
          len_d   = ADDR_SZ'(i_data_len >> (int'(sel_ch) * ADDR_SZ));
          state_d = sel_wr ? S_WR : S_RD;
        end
      end
      S_WR: begin
        cnt_d = cnt_q + 1'b1;
        if (i_wr_dn) state_d = S_FIN;
        else if (cnt_q == T_LAST) state_d = S_ERR;
      end
      S_RD: begin
        cnt_d = cnt_q + 1'b1;
        if (i_rd_dn) state_d = S_FIN;
        else if (cnt_q == T_LAST) state_d = S_ERR;
      end
      S_FIN, S_ERR: begin
        state_d = S_IDLE;
        ptr_d   = ptr_nxt;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d   = (state_d != S_IDLE);
    wr_irq_d = (state_d == S_WR);
    rd_irq_d = (state_d == S_RD);
    grant_d  = (wr_irq_d | rd_irq_d) ? CH_NUM'(1) << ch_d : '0;
    done_d   = (state_d == S_FIN || state_d == S_ERR)
             ? CH_NUM'(1) << ch_q : '0;
    err_d    = (state_d == S_ERR) ? CH_NUM'(1) << ch_q : '0;
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      ch_q     <= '0;
      cnt_q    <= '0;
      grant_q  <= '0;
      done_q   <= '0;
      err_q    <= '0;
      busy_q   <= 1'b0;
      wr_irq_q <= 1'b0;
      rd_irq_q <= 1'b0;
      addr_q   <= '0;
      len_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      ch_q     <= ch_d;
      cnt_q    <= cnt_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      wr_irq_q <= wr_irq_d;
      rd_irq_q <= rd_irq_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
    end
  end

  assign o_grant       = grant_q;
  assign o_done        = done_q;
  assign o_err         = err_q;
  assign o_busy        = busy_q;
  assign o_wr_irq      = wr_irq_q;
  assign o_rd_irq      = rd_irq_q;
  assign o_addr_offset = addr_q;
  assign o_data_len    = len_q;

endmodule

// File: tb/tb_flash_access_arb.sv
// Randomized bench for flash_access_arb against a transaction-level
// model of round-robin selection, watchdog and completion.
module tb_flash_access_arb;

  localparam int CH = 3;
  localparam int AW = 16;
  localparam int TW = 8;
  localparam int TM = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [CH-1:0]   wr_req, rd_req;
  logic [CH*AW-1:0] addr_bus, len_bus;
  logic [CH-1:0]   grant, done, err;
  logic            busy, wr_irq, rd_irq;
  logic [AW-1:0]   addr_o, len_o;
  logic            wr_dn, rd_dn, scl_w, scl_r, scl;

  logic [AW-1:0]   addr_a [CH];
  logic [AW-1:0]   len_a  [CH];

  int total = 0;
  int bad   = 0;
  int ptr_m = 0;

  always #5 clk = ~clk;

  flash_access_arb #(
    .CH_NUM(CH), .ADDR_SZ(AW), .TOUT_W(TW), .TOUT_MAX(8'(TM))
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_wr_req(wr_req), .i_rd_req(rd_req),
    .i_addr_offset(addr_bus), .i_data_len(len_bus),
    .o_grant(grant), .o_done(done), .o_err(err),
    .o_busy(busy), .o_wr_irq(wr_irq), .o_rd_irq(rd_irq),
    .o_addr_offset(addr_o), .o_data_len(len_o),
    .i_wr_dn(wr_dn), .i_rd_dn(rd_dn),
    .i_scl_w(scl_w), .i_scl_r(scl_r), .o_scl(scl)
  );

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic scramble();
    for (int c = 0; c < CH; c++) begin
      addr_a[c] = AW'($urandom);
      len_a[c]  = AW'($urandom);
      addr_bus[c*AW +: AW] = addr_a[c];
      len_bus[c*AW +: AW]  = len_a[c];
    end
    scl_w = 1'($urandom);
    scl_r = 1'($urandom);
  endtask

  function automatic int pick();
    for (int i = 0; i < CH; i++) begin
      int c;
      c = (ptr_m + i) % CH;
      if (wr_req[c] | rd_req[c]) return c;
    end
    return -1;
  endfunction

  task automatic check_zero(string tag);
    check({tag, "_grant"}, 32'(grant), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_err"}, 32'(err), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_irq"}, {30'd0, wr_irq, rd_irq}, 0);
    check({tag, "_addr"}, 32'(addr_o), 0);
    check({tag, "_len"}, 32'(len_o), 0);
  endtask

  initial begin
    int k, jd;
    bit is_wr, tout, rst_now, rst_done;
    logic [CH-1:0] oh;
    logic [AW-1:0] ea, el;
    wr_req = '0; rd_req = '0;
    wr_dn = 1'b0; rd_dn = 1'b0;
    rst_done = 1'b0;
    scramble();
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    for (int op = 0; op < 80; op++) begin
      check("idle_busy", 32'(busy), 0);
      check("idle_done", 32'(done), 0);
      scramble();
      for (int c = 0; c < CH; c++) begin
        if (!wr_req[c] && $urandom_range(0, 2) == 0) wr_req[c] = 1'b1;
        if (!rd_req[c] && $urandom_range(0, 2) == 0) rd_req[c] = 1'b1;
      end
      wr_dn = ($urandom_range(0, 3) == 0);
      rd_dn = ($urandom_range(0, 3) == 0);
      #1;
      check("scl", 32'(scl), 32'(scl_w | scl_r));
      k = pick();
      if (k < 0) begin
        @(negedge clk);
        continue;
      end
      is_wr = wr_req[k];
      ea = addr_a[k];
      el = len_a[k];
      oh = '0;
      oh[k] = 1'b1;
      jd = $urandom_range(0, 11);
      rst_now = !rst_done && op >= 30 && !is_wr;
      if (rst_now) jd = 9;
      for (int j = 0; j < TM; j++) begin
        @(negedge clk);
        check("op_grant", 32'(grant), 32'(oh));
        check("op_busy", 32'(busy), 1);
        check("op_irq", {30'd0, wr_irq, rd_irq}, {30'd0, is_wr, !is_wr});
        check("op_addr", 32'(addr_o), 32'(ea));
        check("op_len", 32'(len_o), 32'(el));
        scramble();
        if (rst_now && j == 2) begin
          rst_n = 1'b0;
          wr_dn = 1'b0;
          rd_dn = 1'b0;
          #1;
          check_zero("midrst");
          break;
        end
        if (j == 1 && $urandom_range(0, 2) == 0) begin
          if (is_wr) wr_req[k] = 1'b0;
          else rd_req[k] = 1'b0;
        end
        wr_dn = is_wr ? (j == jd) : ($urandom_range(0, 2) == 0);
        rd_dn = !is_wr ? (j == jd) : ($urandom_range(0, 2) == 0);
        if (j == jd) break;
      end
      if (rst_now) begin
        @(negedge clk);
        rst_n = 1'b1;
        rst_done = 1'b1;
        ptr_m = 0;
        continue;
      end
      tout = (jd >= TM);
      @(negedge clk);
      wr_dn = 1'($urandom);
      rd_dn = 1'($urandom);
      check("end_done", 32'(done), 32'(oh));
      check("end_err", 32'(err), tout ? 32'(oh) : 0);
      check("end_grant", 32'(grant), 0);
      check("end_irq", {30'd0, wr_irq, rd_irq}, 0);
      check("end_busy", 32'(busy), 1);
      if (is_wr) wr_req[k] = 1'b0;
      else rd_req[k] = 1'b0;
      ptr_m = (k + 1) % CH;
      @(negedge clk);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/flash_access_arb.md
FLASH_ACCESS_ARB -- requirements
Module: flash_access_arb

Interface
REQ-001 SHALL have parameter CH_NUM, default 2, number of requesting channels (1..8).
REQ-002 SHALL have parameter ADDR_SZ, default 16, width of address offset and data length.
REQ-003 SHALL have parameter TOUT_W, default 20, width of the engine watchdog counter.
REQ-004 SHALL have parameter TOUT_MAX, default 20'hFFFFF, watchdog limit in cycles.
REQ-005 SHALL have ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  reset; one clock, asynchronous, active-low.
- i_wr_req  in  CH_NUM  per-channel write request, level, held until o_done.
- i_rd_req  in  CH_NUM  per-channel read request, level, held until o_done.
- i_addr_offset  in  CH_NUM*ADDR_SZ  per-channel flash offset; channel k at bits [k*ADDR_SZ +: ADDR_SZ].
- i_data_len  in  CH_NUM*ADDR_SZ  per-channel word count, same packing.
- o_grant  out  CH_NUM  one-hot, channel currently owning the flash.
- o_done  out  CH_NUM  one-cycle completion pulse per channel.
- o_err  out  CH_NUM  one-cycle timeout pulse per channel.
- o_busy  out  1  high whenever state is not IDLE.
- o_wr_irq  out  1  start/hold level to the write engine.
- o_rd_irq  out  1  start/hold level to the read engine.
- o_addr_offset  out  ADDR_SZ  latched offset of the granted channel.
- o_data_len  out  ADDR_SZ  latched length of the granted channel.
- i_wr_dn  in  1  write engine done pulse.
- i_rd_dn  in  1  read engine done pulse.
- i_scl_w  in  1  write engine SCL.
- i_scl_r  in  1  read engine SCL.
- o_scl  out  1  merged SCL to the flash.

Function
REQ-006 SHALL implement states IDLE, WR, RD, FIN, ERR; all outputs except o_scl registered.
REQ-007 SHALL, in IDLE, select the first channel k with i_wr_req[k]|i_rd_req[k], searching from round-robin pointer ptr upward with wrap-around modulo CH_NUM.
REQ-008 SHALL give write priority within a channel: wr_req and rd_req both high -> WR.
REQ-009 SHALL, on the cycle after selection, present o_grant[k]=1, o_busy=1, o_wr_irq or o_rd_irq=1, o_addr_offset/o_data_len = channel k values latched at selection.
REQ-010 SHALL hold latched address/length and irq stable for the whole operation regardless of input changes.
REQ-011 SHALL, in WR, leave on i_wr_dn=1; in RD, leave on i_rd_dn=1; the other engine's done is ignored.
REQ-012 SHALL, on the cycle after done, enter FIN: irq=0, o_grant=0, o_done[k]=1 for exactly one cycle; next cycle IDLE.
REQ-013 SHALL count cycles in WR/RD starting at 0 on entry; when count reaches TOUT_MAX with no done, enter ERR: irq=0, o_grant=0, o_done[k]=1 and o_err[k]=1 for one cycle; next cycle IDLE.
REQ-014 SHALL treat done and timeout in the same cycle as normal completion (o_err stays 0).
REQ-015 SHALL set ptr=(k+1) mod CH_NUM on FIN or ERR; with CH_NUM=1 ptr stays 0.
REQ-016 SHALL ignore request deassertion mid-operation; the operation completes and o_done still pulses.
REQ-017 SHALL ignore i_wr_dn/i_rd_dn in IDLE, FIN, ERR.
REQ-018 SHALL drive o_scl = i_scl_w | i_scl_r combinationally.
REQ-019 SHALL need at least one IDLE cycle between operations (minimum 4 cycles request-to-request including 1-cycle engine).

Reset
REQ-020 SHALL, while i_rst_n=0, force state IDLE, ptr=0, counter=0, and all registered outputs (o_grant, o_done, o_err, o_busy, irqs, o_addr_offset, o_data_len) to 0 immediately, including mid-operation.
REQ-021 SHALL start arbitration on the first i_clk rising edge after reset release.

Verification
REQ-022 Ch0 wr_req, offset 0x0010, len 0x0004; i_wr_dn 5 cycles after irq -> o_grant=01, o_wr_irq=1, o_addr_offset=0x0010, then o_done=01 one cycle, o_err=00.
REQ-023 Ch0 and ch1 rd_req simultaneous after reset -> ch0 served first, then ch1; next simultaneous pair -> ch0 (ptr back at 0); with ptr=1 pending both -> ch1 first.
REQ-024 Ch1 wr_req and rd_req both high -> o_wr_irq only; after done, ch1 rd served in a later grant.
REQ-025 TOUT_MAX=8, no done -> irq high 8 cycles, o_done[k]=o_err[k]=1 one cycle, return IDLE; done arriving on cycle 8 -> o_err=0.
REQ-026 Reset asserted during RD with irq high -> all outputs 0 same cycle; after release, still-held request re-granted from ch0.
REQ-027 i_rd_dn pulse during WR and i_wr_dn in IDLE -> no state change, no o_done.
